call_scheduler: RTL and testbench

- Collective (SCAN) call scheduler for the 4-floor elevator car.
- Latches hall-up, hall-down and car-call buttons and tracks car position from the floor sensors.
- Decides up/down/stop motion and times the door dwell.
- Sits between the button/sensor inputs and the motor/door drive. Its monitor output feeds the floor display.

---
 rtl/elevator_pkg.sv | 56 +++++
 rtl/door_timer.sv | 35 +++
 rtl/call_scheduler.sv | 158 +++++++++++++++
 tb/tb_call_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and floor-index helpers for the 4-floor collective call scheduler.
package elevator_pkg;

  localparam int NFLOORS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } floor_idx_t;

  // Exactly one-hot input gives valid=1; all-zero or multi-hot gives valid=0.
  function automatic floor_idx_t onehot_to_idx(input logic [NFLOORS-1:0] v);
    floor_idx_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (v)
      4'b0001: r.idx = 2'd0;
      4'b0010: r.idx = 2'd1;
      4'b0100: r.idx = 2'd2;
      4'b1000: r.idx = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [NFLOORS-1:0] above_mask(input logic [1:0] f);
    logic [NFLOORS-1:0] m;
    for (int i = 0; i < NFLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [NFLOORS-1:0] below_mask(input logic [1:0] f);
    logic [NFLOORS-1:0] m;
    for (int i = 0; i < NFLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  function automatic logic [NFLOORS-1:0] floor_bit(input logic [1:0] f);
    logic [NFLOORS-1:0] m;
    for (int i = 0; i < NFLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

endpackage

// File: rtl/door_timer.sv
// Door dwell down-counter: load/reload to DOOR_CYCLES-1, count down while enabled, done at zero.
module door_timer #(
  parameter int DOOR_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(DOOR_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(DOOR_CYCLES - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/call_scheduler.sv
// SCAN call scheduler: latches hall/car calls, tracks car position, drives motor and door.
module call_scheduler #(
  parameter int NFLOORS     = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NFLOORS-1:0]         floor_sensor,
  input  logic [NFLOORS-1:0]         hall_up,
  input  logic [NFLOORS-1:0]         hall_dn,
  input  logic [NFLOORS-1:0]         car_call,
  output logic                       up,
  output logic                       down,
  output logic                       stop,
  output logic                       open_door,
  output logic [$clog2(NFLOORS)-1:0] monitor,
  output logic [NFLOORS-1:0]         pending
);

  import elevator_pkg::*;

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [1:0] pos_q, pos_d;
  logic [3:0] up_req_q, up_req_d;
  logic [3:0] dn_req_q, dn_req_d;
  logic [3:0] car_req_q, car_req_d;
  logic [3:0] pending_q, pending_d;

  floor_idx_t sens;
  logic [3:0] in_up, in_dn, in_car;
  logic [3:0] all_q, all_set;
  logic [3:0] door_fm, clr_fm;
  logic [3:0] clr_car, clr_up, clr_dn;
  logic       above, below, here;
  logic       enter, flip, svc, served_press;
  logic [1:0] enter_floor;
  logic       door_load, door_en, door_done;

  always_comb begin
    sens    = onehot_to_idx(floor_sensor);
    in_up   = hall_up & 4'b0111;
    in_dn   = hall_dn & 4'b1110;
    in_car  = car_call;
    all_q   = up_req_q | dn_req_q | car_req_q;
    all_set = all_q | in_up | in_dn | in_car;
    above   = |(all_q & above_mask(pos_q));
    below   = |(all_q & below_mask(pos_q));
    here    = all_q[pos_q];

    state_d      = state_q;
    dir_d        = dir_q;
    pos_d        = sens.valid ? sens.idx : pos_q;
    enter        = 1'b0;
    enter_floor  = pos_q;
    door_en      = 1'b0;
    door_fm      = floor_bit(pos_q);
    served_press = 1'b0;
    flip         = 1'b0;

    case (state_q)
      IDLE: begin
        if (here && sens.valid && (sens.idx == pos_q)) begin
          enter = 1'b1;
        end else if (above && ((dir_q == DIR_UP) || !below)) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (below) begin
          state_d = MOVE_DN;
          dir_d   = DIR_DN;
        end
      end
      MOVE_UP: begin
        // Top sensor always stops the car, even with nothing requested there.
        if (sens.valid && ((sens.idx == 2'd3) ||
            ((sens.idx != pos_q) && (car_req_q[sens.idx] || up_req_q[sens.idx] ||
             !(|(all_q & above_mask(sens.idx))))))) begin
          enter       = 1'b1;
          enter_floor = sens.idx;
        end
      end
      MOVE_DN: begin
        if (sens.valid && ((sens.idx == 2'd0) ||
            ((sens.idx != pos_q) && (car_req_q[sens.idx] || dn_req_q[sens.idx] ||
             !(|(all_q & below_mask(sens.idx))))))) begin
          enter       = 1'b1;
          enter_floor = sens.idx;
        end
      end
      DOOR: begin
        door_en      = 1'b1;
        served_press = (|(in_car & door_fm)) ||
                       ((dir_q == DIR_UP) ? (|(in_up & door_fm)) : (|(in_dn & door_fm)));
        if (!served_press && door_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      state_d = DOOR;
      flip = (dir_q == DIR_UP) ? !(|(all_set & above_mask(enter_floor)))
                               : !(|(all_set & below_mask(enter_floor)));
      if (flip) dir_d = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
    end

    door_load = enter || served_press;

    // Served calls at the door floor are cleared on entry and masked for the whole dwell.
    svc     = enter || (state_q == DOOR);
    clr_fm  = floor_bit(enter ? enter_floor : pos_q);
    clr_car = svc ? clr_fm : 4'b0000;
    clr_up  = (svc && ((dir_q == DIR_UP) || (enter && flip))) ? clr_fm : 4'b0000;
    clr_dn  = (svc && ((dir_q == DIR_DN) || (enter && flip))) ? clr_fm : 4'b0000;

    up_req_d  = (up_req_q  | in_up)  & ~clr_up;
    dn_req_d  = (dn_req_q  | in_dn)  & ~clr_dn;
    car_req_d = (car_req_q | in_car) & ~clr_car;
    pending_d = up_req_d | dn_req_d | car_req_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      pos_q     <= 2'd0;
      up_req_q  <= 4'b0000;
      dn_req_q  <= 4'b0000;
      car_req_q <= 4'b0000;
      pending_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      up_req_q  <= up_req_d;
      dn_req_q  <= dn_req_d;
      car_req_q <= car_req_d;
      pending_q <= pending_d;
    end
  end

  door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk  (clk),
    .rst  (reset),
    .load (door_load),
    .en   (door_en),
    .done (door_done)
  );

  assign up        = (state_q == MOVE_UP);
  assign down      = (state_q == MOVE_DN);
  assign stop      = (state_q == IDLE) || (state_q == DOOR);
  assign open_door = (state_q == DOOR);
  assign monitor   = pos_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Directed scenario bench for call_scheduler with hand-computed expectations.
module tb_call_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] floor_sensor, hall_up, hall_dn, car_call;
  logic       up, down, stop, open_door;
  logic [1:0] monitor;
  logic [3:0] pending;

  int checks   = 0;
  int failures = 0;

  call_scheduler #(.NFLOORS(4), .DOOR_CYCLES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .floor_sensor (floor_sensor),
    .hall_up      (hall_up),
    .hall_dn      (hall_dn),
    .car_call     (car_call),
    .up           (up),
    .down         (down),
    .stop         (stop),
    .open_door    (open_door),
    .monitor      (monitor),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    floor_sensor = 4'b0000; hall_up = 4'b0000; hall_dn = 4'b0000; car_call = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  // Counts consecutive cycles with open_door high, starting with the current one.
  task automatic count_door(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (open_door !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({up, down, stop, open_door} !== 4'b0010) begin failures++; $display("FAIL reset_motion got=%b exp=0010", {up, down, stop, open_door}); end
    checks++; if (monitor !== 2'd0) begin failures++; $display("FAIL reset_monitor got=%0d exp=0", monitor); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
  endtask

  task automatic test_single_call();
    int n;
    floor_sensor = 4'b0001; tick();
    hall_up = 4'b0010; tick();
    hall_up = 4'b0000;
    checks++; if (up !== 1'b0 || pending !== 4'b0010) begin failures++; $display("FAIL t1_latch up=%b pending=%b exp up=0 pending=0010", up, pending); end
    tick();
    checks++; if (up !== 1'b1) begin failures++; $display("FAIL t1_start up=%b exp=1", up); end
    floor_sensor = 4'b0000; tick();
    checks++; if (up !== 1'b1 || monitor !== 2'd0) begin failures++; $display("FAIL t1_between up=%b mon=%0d exp up=1 mon=0", up, monitor); end
    floor_sensor = 4'b0010; tick();
    checks++; if ({up, stop, open_door} !== 3'b011 || monitor !== 2'd1 || pending !== 4'b0000) begin
      failures++; $display("FAIL t1_arrive usd=%b mon=%0d pend=%b exp usd=011 mon=1 pend=0000", {up, stop, open_door}, monitor, pending); end
    count_door(n);
    checks++; if (n != 3) begin failures++; $display("FAIL t1_dwell got=%0d exp=3", n); end
    checks++; if ({up, down, stop} !== 3'b001) begin failures++; $display("FAIL t1_idle got=%b exp=001", {up, down, stop}); end
  endtask

  task automatic test_pass_through();
    int n;
    hall_dn = 4'b1000; tick();
    tick();
    checks++; if (up !== 1'b1) begin failures++; $display("FAIL t2_start up=%b exp=1", up); end
    hall_dn = 4'b0000;
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0100; tick();
    checks++; if (up !== 1'b1 || monitor !== 2'd2 || open_door !== 1'b0) begin
      failures++; $display("FAIL t2_pass2 up=%b mon=%0d door=%b exp up=1 mon=2 door=0", up, monitor, open_door); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b1000; tick();
    checks++; if (open_door !== 1'b1 || monitor !== 2'd3 || pending !== 4'b0000) begin
      failures++; $display("FAIL t2_arrive3 door=%b mon=%0d pend=%b exp door=1 mon=3 pend=0000", open_door, monitor, pending); end
    count_door(n);
    checks++; if (n != 3) begin failures++; $display("FAIL t2_dwell got=%0d exp=3", n); end
  endtask

  task automatic test_scan_order();
    int n;
    do_reset();
    floor_sensor = 4'b0100; tick();
    checks++; if (monitor !== 2'd2) begin failures++; $display("FAIL t3_pos got=%0d exp=2", monitor); end
    car_call = 4'b1001; tick();
    car_call = 4'b0000; tick();
    checks++; if (up !== 1'b1 || down !== 1'b0) begin failures++; $display("FAIL t3_up_first up=%b down=%b exp up=1 down=0", up, down); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b1000; tick();
    checks++; if (open_door !== 1'b1 || monitor !== 2'd3 || pending !== 4'b0001) begin
      failures++; $display("FAIL t3_at3 door=%b mon=%0d pend=%b exp door=1 mon=3 pend=0001", open_door, monitor, pending); end
    count_door(n);
    checks++; if (n != 3) begin failures++; $display("FAIL t3_dwell3 got=%0d exp=3", n); end
    tick();
    checks++; if (down !== 1'b1) begin failures++; $display("FAIL t3_down down=%b exp=1", down); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0100; tick();
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0010; tick();
    checks++; if (down !== 1'b1 || monitor !== 2'd1) begin failures++; $display("FAIL t3_pass1 down=%b mon=%0d exp down=1 mon=1", down, monitor); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0001; tick();
    checks++; if (open_door !== 1'b1 || monitor !== 2'd0 || pending !== 4'b0000) begin
      failures++; $display("FAIL t3_at0 door=%b mon=%0d pend=%b exp door=1 mon=0 pend=0000", open_door, monitor, pending); end
    count_door(n);
    checks++; if (n != 3) begin failures++; $display("FAIL t3_dwell0 got=%0d exp=3", n); end
  endtask

  task automatic test_skip_opposite_hall();
    int n;
    do_reset();
    floor_sensor = 4'b0001; tick();
    hall_dn = 4'b0010; car_call = 4'b1000; tick();
    hall_dn = 4'b0000; car_call = 4'b0000; tick();
    checks++; if (up !== 1'b1) begin failures++; $display("FAIL t4_start up=%b exp=1", up); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0010; tick();
    checks++; if (up !== 1'b1 || open_door !== 1'b0 || monitor !== 2'd1 || pending !== 4'b1010) begin
      failures++; $display("FAIL t4_skip1 up=%b door=%b mon=%0d pend=%b exp up=1 door=0 mon=1 pend=1010", up, open_door, monitor, pending); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0100; tick();
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b1000; tick();
    checks++; if (open_door !== 1'b1 || monitor !== 2'd3 || pending !== 4'b0010) begin
      failures++; $display("FAIL t4_at3 door=%b mon=%0d pend=%b exp door=1 mon=3 pend=0010", open_door, monitor, pending); end
    count_door(n);
    tick();
    checks++; if (down !== 1'b1) begin failures++; $display("FAIL t4_down down=%b exp=1", down); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0100; tick();
    checks++; if (down !== 1'b1 || open_door !== 1'b0) begin failures++; $display("FAIL t4_pass2 down=%b door=%b exp down=1 door=0", down, open_door); end
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0010; tick();
    checks++; if (open_door !== 1'b1 || monitor !== 2'd1 || pending !== 4'b0000) begin
      failures++; $display("FAIL t4_at1 door=%b mon=%0d pend=%b exp door=1 mon=1 pend=0000", open_door, monitor, pending); end
  endtask

  task automatic test_door_reload();
    int n;
    do_reset();
    floor_sensor = 4'b0100; tick();
    car_call = 4'b0100; tick();
    car_call = 4'b0000; tick();
    checks++; if ({stop, open_door} !== 2'b11 || pending !== 4'b0000) begin
      failures++; $display("FAIL t5_open sd=%b pend=%b exp sd=11 pend=0000", {stop, open_door}, pending); end
    car_call = 4'b0100; tick();
    car_call = 4'b0000;
    checks++; if (open_door !== 1'b1 || pending !== 4'b0000) begin
      failures++; $display("FAIL t5_press door=%b pend=%b exp door=1 pend=0000", open_door, pending); end
    count_door(n);
    checks++; if (n != 3) begin failures++; $display("FAIL t5_extend got=%0d exp=3", n); end
  endtask

  task automatic test_async_reset_multihot();
    do_reset();
    floor_sensor = 4'b0001; tick();
    car_call = 4'b1000; tick();
    car_call = 4'b0000; tick();
    floor_sensor = 4'b0000; tick();
    floor_sensor = 4'b0010; tick();
    checks++; if (up !== 1'b1 || monitor !== 2'd1) begin failures++; $display("FAIL t6_pass1 up=%b mon=%0d exp up=1 mon=1", up, monitor); end
    floor_sensor = 4'b0110; tick();
    checks++; if (up !== 1'b1 || stop !== 1'b0 || monitor !== 2'd1) begin
      failures++; $display("FAIL t6_multihot up=%b stop=%b mon=%0d exp up=1 stop=0 mon=1", up, stop, monitor); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({up, down, stop, open_door} !== 4'b0010 || monitor !== 2'd0 || pending !== 4'b0000) begin
      failures++; $display("FAIL t6_async udso=%b mon=%0d pend=%b exp udso=0010 mon=0 pend=0000", {up, down, stop, open_door}, monitor, pending); end
    tick();
    reset = 1'b0;
    floor_sensor = 4'b0000;
  endtask

  initial begin
    reset = 1'b1;
    floor_sensor = 4'b0000; hall_up = 4'b0000; hall_dn = 4'b0000; car_call = 4'b0000;
    test_reset();
    test_single_call();
    test_pass_through();
    test_scan_order();
    test_skip_opposite_hall();
    test_door_reload();
    test_async_reset_multihot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
